// File: rtl/uart_rx_fifo.sv
// UART 8N1 receive path: 2-flop synchronizer, mid-bit sampling receiver FSM
// and a show-ahead byte FIFO presenting received bytes on a valid/ready stream.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Sample points: half a bit after the start edge, then every full bit.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Synchronizer
  logic            r_sync1;
  logic            r_sync2;
  logic            w_rs;

  // Receiver
  state_t          r_state;
  state_t          w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_cnt_clr;
  logic            w_shift_en;
  logic            w_push_req;
  logic            w_frame_err;

  // FIFO
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_overrun;

  // Error pulses
  logic            r_frame_err;
  logic            r_overrun;

  assign w_rs = r_sync2;

  // Bring the asynchronous line into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Receiver next-state logic and per-cycle sample strobes.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_push_req   = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rs) begin
          w_next_state = S_START;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_clr = 1'b1;
          // A line that is high again at mid start bit was only a glitch.
          if (!w_rs) begin
            w_next_state = S_DATA;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_START;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_next_state = S_STOP;
          end else begin
            w_next_state = S_DATA;
          end
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_clr = 1'b1;
          if (w_rs) begin
            w_push_req   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = S_BREAK;
          end
        end else begin
          w_next_state = S_STOP;
        end
      end
      S_BREAK: begin
        // Hold here until the line is released so a long break reports once.
        w_cnt_clr = 1'b1;
        if (w_rs) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_BREAK;
        end
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Baud counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_shift_en) begin
        r_shift   <= {w_rs, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_shift   <= r_shift;
        r_bit_idx <= r_bit_idx;
      end
    end
  end

  // A pop on a full FIFO frees the slot the completing byte needs.
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = rx_valid && rx_ready;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_overrun = w_push_req && w_full && !w_pop;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Register the error pulses; they come from exclusive stop-bit outcomes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

  assign rx_data    = r_mem[r_rd_ptr];
  assign rx_valid   = (r_count != {CW{1'b0}});
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
